// File: rtl/edge_event_unit.sv
// edge_event_unit: multi-channel input conditioner. Each channel is
// synchronised, debounced and edge-detected according to a shared mode.
// Qualified edges give 1-cycle pulses, sticky flags and a shared
// saturating event counter with a latched overflow flag.
module edge_event_unit #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    din,
  input  logic [1:0]             mode,
  input  logic                   clear,
  output logic [CHANNELS-1:0]    pulse,
  output logic [CHANNELS-1:0]    sticky,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  // popcount width: enough to hold up to 8 simultaneous pulses
  localparam int PW = 4;
  localparam logic [DW-1:0]          DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  // number of set bits in a pulse vector
  function automatic logic [PW-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [PW-1:0] n;
    n = {PW{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  logic [CHANNELS-1:0]      sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0]      sync_s;
  logic [DW-1:0]            dcnt_r     [CHANNELS];
  logic [DW-1:0]            dcnt_nxt_s [CHANNELS];
  logic [CHANNELS-1:0]      db_r;
  logic [CHANNELS-1:0]      accept_s;
  logic [CHANNELS-1:0]      rise_s;
  logic [CHANNELS-1:0]      fall_s;
  logic [CHANNELS-1:0]      edge_s;
  logic [COUNT_WIDTH+PW-1:0] sum_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // shift the raw asynchronous inputs through the synchroniser chain
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {CHANNELS{1'b0}};
      end
    end else begin
      sync_r[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // count consecutive cycles the synchronised level differs from the
  // accepted level; accept it on the cycle the run would hit the limit
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      accept_s[i]   = 1'b0;
      dcnt_nxt_s[i] = {DW{1'b0}};
      if (sync_s[i] == db_r[i]) begin
        dcnt_nxt_s[i] = {DW{1'b0}};
      end else if (dcnt_r[i] == DB_LAST) begin
        accept_s[i]   = 1'b1;
        dcnt_nxt_s[i] = {DW{1'b0}};
      end else begin
        dcnt_nxt_s[i] = dcnt_r[i] + DW'(1);
      end
    end
  end

  // an accepted change always moves db toward the synchronised level,
  // so its direction is given by the new level alone
  assign rise_s = accept_s & sync_s;
  assign fall_s = accept_s & ~sync_s;

  // pick which accepted transitions qualify as events for the current mode
  always_comb begin
    edge_s = {CHANNELS{1'b0}};
    case (mode)
      2'b00:   edge_s = rise_s;
      2'b01:   edge_s = fall_s;
      2'b10:   edge_s = rise_s | fall_s;
      2'b11:   edge_s = {CHANNELS{1'b0}};
      default: edge_s = {CHANNELS{1'b0}};
    endcase
  end

  // register debounce counters, accepted levels and the edge pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt_r[i] <= {DW{1'b0}};
      end
      db_r  <= {CHANNELS{1'b0}};
      pulse <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt_r[i] <= dcnt_nxt_s[i];
      end
      db_r  <= db_r ^ accept_s;
      pulse <= edge_s;
    end
  end

  // widened sum so the saturation test sees the true total
  assign sum_s = {{PW{1'b0}}, count} + {{COUNT_WIDTH{1'b0}}, popcount(pulse)};

  // latch pulses into sticky flags and the saturating counter; clear wins
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky   <= {CHANNELS{1'b0}};
      count    <= {COUNT_WIDTH{1'b0}};
      overflow <= 1'b0;
    end else if (clear) begin
      sticky   <= {CHANNELS{1'b0}};
      count    <= {COUNT_WIDTH{1'b0}};
      overflow <= 1'b0;
    end else begin
      sticky <= sticky | pulse;
      if (sum_s > {{PW{1'b0}}, COUNT_MAX}) begin
        count    <= COUNT_MAX;
        overflow <= 1'b1;
      end else begin
        count    <= sum_s[COUNT_WIDTH-1:0];
      end
    end
  end

endmodule
